// File: rtl/mipi_rx_pkg.sv
// ============================================================================
// mipi_rx_pkg : shared CSI-2 receive constants, header field map, FSM states
// Rev 1.0
// ============================================================================
`default_nettype none

package mipi_rx_pkg;

   localparam logic [5:0] DT_FS       = 6'h00;
   localparam logic [5:0] DT_FE       = 6'h01;
   localparam logic [5:0] DT_RAW10    = 6'h2B;
   localparam logic [5:0] DT_LONG_MIN = 6'h10;

   // Packet header layout: WC is little-endian, byte 1 in [15:8]
   localparam int HDR_DT_LSB  = 0;
   localparam int HDR_DT_MSB  = 5;
   localparam int HDR_VC_LSB  = 6;
   localparam int HDR_VC_MSB  = 7;
   localparam int HDR_WC_LSB  = 8;
   localparam int HDR_WC_MSB  = 23;
   localparam int HDR_ECC_LSB = 24;
   localparam int HDR_ECC_MSB = 31;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_PAYLOAD = 2'd1;
   localparam logic [1:0] ST_CRC     = 2'd2;
   localparam logic [1:0] ST_DRAIN   = 2'd3;

   function automatic logic is_short_packet(input logic [5:0] dt);
      return (dt < DT_LONG_MIN);
   endfunction

endpackage

`default_nettype wire

// File: rtl/mipi_rx_raw10_line_ctrl.sv
// ============================================================================
// mipi_rx_raw10_line_ctrl : header decode and payload gating ahead of the
// raw10 depacker; frame/line pulses and per-frame line counter.
// Rev 1.0
// ============================================================================
`default_nettype none

module mipi_rx_raw10_line_ctrl
   import mipi_rx_pkg::*;
#(
   parameter logic [5:0]  DATA_TYPE = 6'h2B,
   parameter logic [1:0]  VC        = 2'd0,
   parameter logic [15:0] MAX_WC    = 16'd10240
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        data_valid_i,
   input  logic [31:0] data_i,
   output logic        depacker_valid_o,
   output logic [31:0] depacker_data_o,
   output logic        frame_start_o,
   output logic        frame_end_o,
   output logic        line_start_o,
   output logic        line_end_o,
   output logic [15:0] line_count_o,
   output logic        packet_error_o
);

   logic [1:0]  state_q,        state_d;
   logic [13:0] cnt_q,          cnt_d;
   logic        valid_prev_q,   valid_prev_d;
   logic        dep_valid_q,    dep_valid_d;
   logic [31:0] dep_data_q,     dep_data_d;
   logic        fs_q,           fs_d;
   logic        fe_q,           fe_d;
   logic        ls_q,           ls_d;
   logic        le_q,           le_d;
   logic        err_q,          err_d;
   logic [15:0] line_count_q,   line_count_d;

   logic [5:0]  hdr_dt;
   logic [1:0]  hdr_vc;
   logic [15:0] hdr_wc;
   logic        pkt_start;

   assign hdr_dt    = data_i[HDR_DT_MSB:HDR_DT_LSB];
   assign hdr_vc    = data_i[HDR_VC_MSB:HDR_VC_LSB];
   assign hdr_wc    = data_i[HDR_WC_MSB:HDR_WC_LSB];
   assign pkt_start = data_valid_i && !valid_prev_q;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      valid_prev_d = data_valid_i;
      dep_valid_d  = 1'b0;
      dep_data_d   = dep_data_q;
      fs_d         = 1'b0;
      fe_d         = 1'b0;
      ls_d         = 1'b0;
      le_d         = 1'b0;
      err_d        = 1'b0;
      line_count_d = line_count_q;

      case (state_q)
         ST_IDLE: begin
            // Only the first word after valid rises is a header
            if (pkt_start) begin
               state_d = ST_DRAIN;
               if (hdr_vc != VC) begin
               end else if (hdr_dt == DT_FS) begin
                  fs_d         = 1'b1;
                  line_count_d = 16'd0;
               end else if (hdr_dt == DT_FE) begin
                  fe_d = 1'b1;
               end else if (is_short_packet(hdr_dt)) begin
               end else if (hdr_dt != DATA_TYPE) begin
               end else if ((hdr_wc > MAX_WC) || (hdr_wc[1:0] != 2'b00)) begin
                  err_d = 1'b1;
               end else begin
                  cnt_d   = hdr_wc[15:2];
                  ls_d    = 1'b1;
                  state_d = (hdr_wc == 16'd0) ? ST_CRC : ST_PAYLOAD;
               end
            end
         end

         ST_PAYLOAD: begin
            if (data_valid_i) begin
               dep_valid_d = 1'b1;
               dep_data_d  = data_i;
               cnt_d       = cnt_q - 14'd1;
               if (cnt_q == 14'd1) begin
                  state_d = ST_CRC;
               end
            end else begin
               err_d   = 1'b1;
               cnt_d   = 14'd0;
               state_d = ST_IDLE;
            end
         end

         ST_CRC: begin
            if (data_valid_i) begin
               le_d    = 1'b1;
               state_d = ST_DRAIN;
               if (line_count_q != 16'hFFFF) begin
                  line_count_d = line_count_q + 16'd1;
               end
            end else begin
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end
         end

         ST_DRAIN: begin
            if (!data_valid_i) begin
               state_d = ST_IDLE;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   // valid_prev resets high so a word already in flight at release is ignored
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q      <= ST_IDLE;
         cnt_q        <= 14'd0;
         valid_prev_q <= 1'b1;
         dep_valid_q  <= 1'b0;
         dep_data_q   <= 32'd0;
         fs_q         <= 1'b0;
         fe_q         <= 1'b0;
         ls_q         <= 1'b0;
         le_q         <= 1'b0;
         err_q        <= 1'b0;
         line_count_q <= 16'd0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         valid_prev_q <= valid_prev_d;
         dep_valid_q  <= dep_valid_d;
         dep_data_q   <= dep_data_d;
         fs_q         <= fs_d;
         fe_q         <= fe_d;
         ls_q         <= ls_d;
         le_q         <= le_d;
         err_q        <= err_d;
         line_count_q <= line_count_d;
      end
   end

   assign depacker_valid_o = dep_valid_q;
   assign depacker_data_o  = dep_data_q;
   assign frame_start_o    = fs_q;
   assign frame_end_o      = fe_q;
   assign line_start_o     = ls_q;
   assign line_end_o       = le_q;
   assign line_count_o     = line_count_q;
   assign packet_error_o   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_mipi_rx_raw10_line_ctrl.sv
// ============================================================================
// tb_mipi_rx_raw10_line_ctrl : directed self-checking bench
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mipi_rx_raw10_line_ctrl;

   logic        clk_i = 1'b0;
   logic        reset_i;
   logic        data_valid_i;
   logic [31:0] data_i;
   logic        depacker_valid_o;
   logic [31:0] depacker_data_o;
   logic        frame_start_o;
   logic        frame_end_o;
   logic        line_start_o;
   logic        line_end_o;
   logic [15:0] line_count_o;
   logic        packet_error_o;

   logic [4:0]  pulses;
   int          checks   = 0;
   int          failures = 0;

   assign pulses = {frame_start_o, frame_end_o, line_start_o, line_end_o, packet_error_o};

   mipi_rx_raw10_line_ctrl dut (
      .clk_i            (clk_i),
      .reset_i          (reset_i),
      .data_valid_i     (data_valid_i),
      .data_i           (data_i),
      .depacker_valid_o (depacker_valid_o),
      .depacker_data_o  (depacker_data_o),
      .frame_start_o    (frame_start_o),
      .frame_end_o      (frame_end_o),
      .line_start_o     (line_start_o),
      .line_end_o       (line_end_o),
      .line_count_o     (line_count_o),
      .packet_error_o   (packet_error_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Apply one word, clock it in, and return 1 time unit after the edge
   task automatic cyc(input logic v, input logic [31:0] d);
      data_valid_i = v;
      data_i       = d;
      @(posedge clk_i);
      #1;
   endtask

   // pulses = {fs, fe, ls, le, err}
   initial begin
      logic [31:0] pay [5];
      int          nvalid;

      for (int i = 0; i < 5; i++) pay[i] = 32'h1111_1111 * (i + 1);

      reset_i      = 1'b1;
      data_valid_i = 1'b0;
      data_i       = 32'd0;
      #1;
      chk("reset_dep_valid", {31'd0, depacker_valid_o}, 32'd0);
      chk("reset_dep_data", depacker_data_o, 32'd0);
      chk("reset_line_count", {16'd0, line_count_o}, 32'd0);
      chk("reset_pulses", {27'd0, pulses}, 32'd0);
      @(posedge clk_i);
      @(posedge clk_i);
      #1;
      reset_i = 1'b0;
      cyc(1'b0, 32'd0);

      // Frame start
      cyc(1'b1, 32'hAB00_0000);
      chk("fs_pulses", {27'd0, pulses}, 32'b10000);
      chk("fs_line_count", {16'd0, line_count_o}, 32'd0);
      cyc(1'b0, 32'd0);
      chk("fs_pulse_end", {27'd0, pulses}, 32'd0);

      // RAW10 line, WC=20
      cyc(1'b1, 32'h0000_142B);
      chk("l1_hdr_pulses", {27'd0, pulses}, 32'b00100);
      chk("l1_hdr_dep_valid", {31'd0, depacker_valid_o}, 32'd0);
      nvalid = 0;
      for (int i = 0; i < 5; i++) begin
         cyc(1'b1, pay[i]);
         chk("l1_dep_valid", {31'd0, depacker_valid_o}, 32'd1);
         chk("l1_dep_data", depacker_data_o, pay[i]);
         if (depacker_valid_o) nvalid++;
      end
      cyc(1'b1, 32'h0000_BEEF);
      chk("l1_crc_dep_valid", {31'd0, depacker_valid_o}, 32'd0);
      chk("l1_crc_pulses", {27'd0, pulses}, 32'b00010);
      chk("l1_line_count", {16'd0, line_count_o}, 32'd1);
      chk("l1_data_hold", depacker_data_o, pay[4]);
      cyc(1'b0, 32'd0);
      if (depacker_valid_o) nvalid++;
      chk("l1_valid_cycles", nvalid, 32'd5);
      chk("l1_le_end", {27'd0, pulses}, 32'd0);

      // Misaligned WC=19
      cyc(1'b1, 32'h0000_132B);
      chk("wc19_pulses", {27'd0, pulses}, 32'b00001);
      chk("wc19_dep_valid", {31'd0, depacker_valid_o}, 32'd0);
      cyc(1'b1, 32'h5555_5555);
      chk("wc19_drain_dep_valid", {31'd0, depacker_valid_o}, 32'd0);
      chk("wc19_drain_pulses", {27'd0, pulses}, 32'd0);
      cyc(1'b0, 32'd0);
      chk("wc19_line_count", {16'd0, line_count_o}, 32'd1);

      // WC=10244 exceeds MAX_WC although aligned
      cyc(1'b1, 32'h0028_042B);
      chk("wc_big_pulses", {27'd0, pulses}, 32'b00001);
      cyc(1'b0, 32'd0);

      // Type 0x2A long packet is silently drained
      nvalid = 0;
      cyc(1'b1, 32'h0000_142A);
      chk("dt2a_hdr_pulses", {27'd0, pulses}, 32'd0);
      for (int i = 0; i < 6; i++) begin
         cyc(1'b1, 32'h0000_0000);
         if (depacker_valid_o || pulses != 5'd0) nvalid++;
      end
      cyc(1'b0, 32'd0);
      if (depacker_valid_o || pulses != 5'd0) nvalid++;
      chk("dt2a_quiet", nvalid, 32'd0);

      // WC=0 line goes straight to CRC
      cyc(1'b1, 32'h0000_002B);
      chk("wc0_hdr_pulses", {27'd0, pulses}, 32'b00100);
      cyc(1'b1, 32'h0000_1234);
      chk("wc0_crc_pulses", {27'd0, pulses}, 32'b00010);
      chk("wc0_dep_valid", {31'd0, depacker_valid_o}, 32'd0);
      chk("wc0_line_count", {16'd0, line_count_o}, 32'd2);
      cyc(1'b0, 32'd0);

      // FS on VC1 is ignored
      cyc(1'b1, 32'h0000_0040);
      chk("vc1_pulses", {27'd0, pulses}, 32'd0);
      chk("vc1_line_count", {16'd0, line_count_o}, 32'd2);
      cyc(1'b0, 32'd0);

      // Frame end
      cyc(1'b1, 32'h0000_0001);
      chk("fe_pulses", {27'd0, pulses}, 32'b01000);
      cyc(1'b0, 32'd0);

      // Valid drops after 2 of 5 payload words
      nvalid = 0;
      cyc(1'b1, 32'h0000_142B);
      cyc(1'b1, 32'hCAFE_0001);
      if (depacker_valid_o) nvalid++;
      cyc(1'b1, 32'hCAFE_0002);
      if (depacker_valid_o) nvalid++;
      chk("drop_dep_data", depacker_data_o, 32'hCAFE_0002);
      cyc(1'b0, 32'd0);
      if (depacker_valid_o) nvalid++;
      chk("drop_pulses", {27'd0, pulses}, 32'b00001);
      cyc(1'b0, 32'd0);
      if (depacker_valid_o) nvalid++;
      chk("drop_valid_cycles", nvalid, 32'd2);
      chk("drop_after_pulses", {27'd0, pulses}, 32'd0);
      chk("drop_line_count", {16'd0, line_count_o}, 32'd2);
      chk("drop_data_hold", depacker_data_o, 32'hCAFE_0002);

      // Asynchronous reset during PAYLOAD
      cyc(1'b1, 32'h0000_142B);
      cyc(1'b1, 32'hDEAD_BEEF);
      chk("rst_pre_dep_valid", {31'd0, depacker_valid_o}, 32'd1);
      #2;
      reset_i = 1'b1;
      #1;
      chk("rst_async_dep_valid", {31'd0, depacker_valid_o}, 32'd0);
      chk("rst_async_dep_data", depacker_data_o, 32'd0);
      chk("rst_async_line_count", {16'd0, line_count_o}, 32'd0);
      @(posedge clk_i);
      #1;
      reset_i = 1'b0;
      // A stale word resembling an FS header must not decode after release
      nvalid = 0;
      for (int i = 0; i < 3; i++) begin
         cyc(1'b1, 32'h0000_0000);
         if (depacker_valid_o || pulses != 5'd0) nvalid++;
      end
      cyc(1'b0, 32'd0);
      if (depacker_valid_o || pulses != 5'd0) nvalid++;
      chk("rst_release_quiet", nvalid, 32'd0);

      cyc(1'b1, 32'h0000_0000);
      chk("rst_fs_pulses", {27'd0, pulses}, 32'b10000);
      cyc(1'b0, 32'd0);
      cyc(1'b1, 32'h0000_142B);
      chk("rst_l_hdr_pulses", {27'd0, pulses}, 32'b00100);
      nvalid = 0;
      for (int i = 0; i < 5; i++) begin
         cyc(1'b1, pay[4 - i]);
         if (depacker_valid_o && depacker_data_o === pay[4 - i]) nvalid++;
      end
      chk("rst_l_payload", nvalid, 32'd5);
      cyc(1'b1, 32'h0000_0F0F);
      chk("rst_l_crc_pulses", {27'd0, pulses}, 32'b00010);
      chk("rst_l_line_count", {16'd0, line_count_o}, 32'd1);
      cyc(1'b0, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire

// File: doc/mipi_rx_raw10_line_ctrl.md
MIPI_RX_RAW10_LINE_CTRL -- requirements
Module: mipi_rx_raw10_line_ctrl

Interface
REQ-001 SHALL have parameter DATA_TYPE, default 6'h2B, the accepted long-packet data type (RAW10).
REQ-002 SHALL have parameter VC, default 2'd0, the accepted virtual channel.
REQ-003 SHALL have parameter MAX_WC, default 16'd10240, the largest accepted word count in bytes.
REQ-004 SHALL have port clk_i, input, 1 bit, the single clock.
REQ-005 SHALL have port reset_i, input, 1 bit, asynchronous active-high reset.
REQ-006 SHALL have port data_valid_i, input, 1 bit, high for the full duration of one packet from the lane aligner.
REQ-007 SHALL have port data_i, input, 32 bits, packet word; the first valid word is the header.
REQ-008 SHALL have port depacker_valid_o, output, 1 bit, driving the raw10 depacker data_valid_i.
REQ-009 SHALL have port depacker_data_o, output, 32 bits, payload word to the depacker data_i.
REQ-010 SHALL have ports frame_start_o, frame_end_o, line_start_o, line_end_o, outputs, 1 bit each, single-cycle pulses.
REQ-011 SHALL have port line_count_o, output, 16 bits, completed lines in the current frame.
REQ-012 SHALL have port packet_error_o, output, 1 bit, single-cycle error pulse.

Function
REQ-013 Header decode SHALL be: data_i[5:0] data type, [7:6] VC, [23:8] WC (byte 1 LSB), [31:24] ECC; ECC is not checked.
REQ-014 FSM SHALL have states IDLE, PAYLOAD, CRC, DRAIN.
REQ-015 IDLE: on the first cycle with data_valid_i=1, the word SHALL be taken as the header.
REQ-016 IDLE: a header with VC mismatch SHALL go to DRAIN with no pulses.
REQ-017 IDLE: a short packet with type 0x00 SHALL pulse frame_start_o, clear line_count_o to 0, and go to DRAIN.
REQ-018 IDLE: a short packet with type 0x01 SHALL pulse frame_end_o and go to DRAIN.
REQ-019 IDLE: any other type below 0x10 SHALL go to DRAIN with no pulses.
REQ-020 IDLE: a long packet with type != DATA_TYPE SHALL go to DRAIN silently.
REQ-021 IDLE: a header of type DATA_TYPE with WC > MAX_WC or WC[1:0] != 0 SHALL pulse packet_error_o and go to DRAIN.
REQ-022 IDLE: a valid header of type DATA_TYPE SHALL load word counter = WC/4, pulse line_start_o, and go to PAYLOAD, or to CRC if WC=0.
REQ-023 PAYLOAD: each cycle with data_valid_i=1 SHALL forward data_i to depacker_data_o with depacker_valid_o=1 one cycle later (registered, latency 1) and decrement the counter.
REQ-024 PAYLOAD: the cycle consuming the last word SHALL move to CRC.
REQ-025 depacker_valid_o SHALL be high for exactly WC/4 cycles per accepted line.
REQ-026 CRC: the next valid word (CRC in bits [15:0]) SHALL be discarded, SHALL pulse line_end_o, SHALL increment line_count_o (saturating at 16'hFFFF), and SHALL go to DRAIN.
REQ-027 PAYLOAD or CRC: data_valid_i=0 SHALL pulse packet_error_o, SHALL deassert depacker_valid_o next cycle, SHALL not pulse line_end_o, and SHALL return to IDLE.
REQ-028 DRAIN: the FSM SHALL stay in DRAIN while data_valid_i=1 and go to IDLE on the first cycle with data_valid_i=0.
REQ-029 A packet SHALL never be decoded from a word other than the first after data_valid_i rises; back-to-back packets require at least one low cycle between them.
REQ-030 depacker_data_o SHALL hold its last value when depacker_valid_o=0.
REQ-031 All pulse outputs SHALL be registered, one cycle after the triggering input word.

Reset
REQ-032 reset_i=1 SHALL immediately force state IDLE, the counter to 0, and all outputs to 0 (line_count_o=0, depacker_data_o=0), independent of clk_i.
REQ-033 Reset asserted mid-line SHALL abort the line with no line_end_o or packet_error_o pulse after release.
REQ-034 The first packet after reset release SHALL be decoded normally.

Structure
REQ-035 Shared package mipi_rx_pkg SHALL hold the data-type constants (FS 0x00, FE 0x01, RAW10 0x2B), header field positions and the FSM state encoding.
REQ-036 The block SHALL contain no sub-module; it sits directly upstream of mipi_rx_raw10_depacker.

Verification
REQ-037 Bench SHALL cover: FS short packet 32'hxx000000 -> frame_start_o pulse, line_count_o=0.
REQ-038 Bench SHALL cover: RAW10 header 32'h0000142B (WC=20) + 5 payload + 1 CRC word -> depacker_valid_o high 5 cycles with data unchanged at latency 1, line_end_o pulse, line_count_o=1.
REQ-039 Bench SHALL cover: header 32'h0000132B (WC=19) -> packet_error_o pulse, depacker_valid_o stays 0, line_count_o unchanged.
REQ-040 Bench SHALL cover: header type 0x2A, WC=20 -> no depacker_valid_o, no pulses, IDLE after valid falls.
REQ-041 Bench SHALL cover: valid drops after 2 of 5 payload words -> depacker_valid_o exactly 2 cycles, packet_error_o pulse, no line_end_o.
REQ-042 Bench SHALL cover: reset_i pulsed during PAYLOAD -> outputs 0 immediately; the following FS + one WC=20 line decodes correctly with line_count_o=1.
